// File: rtl/strobe_pio_pkg.sv
// Shared definitions for strobe_pio: register word addresses, STATUS bit positions
// and the pulse state machine encoding.
package strobe_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_PLEN   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_IRQ_EN  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/strobe_pio_if.sv
// Avalon-MM slave bus bundle for strobe_pio. A write is accepted on every clock
// edge where chipselect && !write_n; readdata is valid combinationally for address.
interface strobe_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/strobe_pio_timer.sv
// Pulse-length down counter: start loads max(len,1), busy while nonzero, and
// expire is high during the final counted cycle.
module strobe_pio_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= (i_len == '0) ? CNT_W'(1) : i_len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy   = (r_cnt != '0);
    assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/strobe_pio.sv
// Avalon-MM output port with set/clear access and a hardware timed toggle pulse.
// Define STROBE_PIO_IRQ_EN to add the irq output and the STATUS irq_en bit.
module strobe_pio
    import strobe_pio_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    strobe_pio_if.slave       bus,
    output logic [DATA_W-1:0] out_port,
`ifdef STROBE_PIO_IRQ_EN
    output logic              irq,
`endif
    output state_e            o_dbg_state
);

    state_e            r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_out;
    logic [CNT_W-1:0]  r_plen;
    logic              r_done;
    logic              r_ovr;
    logic              r_irq_en;
    logic              r_irq;

    logic              w_wr;
    logic [DATA_W-1:0] w_wd;
    logic              w_wr_pulse;
    logic              w_wr_status;
    logic              w_start;
    logic              w_ovr_set;
    logic              w_done_set;
    logic              w_busy;
    logic              w_expire;
    logic [DATA_W-1:0] w_data_nxt;
    logic [DATA_W-1:0] w_mask_nxt;
    logic              w_unused_wd;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wd        = bus.writedata[DATA_W-1:0];
    assign w_wr_pulse  = w_wr && (bus.address == ADDR_PULSE);
    assign w_wr_status = w_wr && (bus.address == ADDR_STATUS);
    assign w_start     = w_wr_pulse && (r_state == IDLE) && (w_wd != '0);
    assign w_ovr_set   = w_wr_pulse && (r_state == ACTIVE);
    assign w_done_set  = (r_state == ACTIVE) && w_expire;
    assign w_unused_wd = ^bus.writedata;

    strobe_pio_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_len    (r_plen),
        .o_busy   (w_busy),
        .o_expire (w_expire)
    );

    always_comb begin
        w_data_nxt = r_data;
        if (w_wr) begin
            case (bus.address)
                ADDR_DATA: w_data_nxt = w_wd;
                ADDR_SET:  w_data_nxt = r_data | w_wd;
                ADDR_CLR:  w_data_nxt = r_data & ~w_wd;
                default:   w_data_nxt = r_data;
            endcase
        end
    end

    always_comb begin
        w_mask_nxt = r_mask;
        if (w_start)         w_mask_nxt = w_wd;
        else if (w_done_set) w_mask_nxt = '0;
    end

    // out_port is registered from next-state values so a write shows on the pins right after its edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_data   <= RESET_VALUE;
            r_mask   <= '0;
            r_out    <= RESET_VALUE;
            r_plen   <= CNT_W'(1);
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_data <= w_data_nxt;
            r_mask <= w_mask_nxt;
            r_out  <= w_data_nxt ^ w_mask_nxt;
            if (w_wr && (bus.address == ADDR_PLEN)) r_plen <= bus.writedata[CNT_W-1:0];
            case (r_state)
                IDLE:   if (w_start)  r_state <= ACTIVE;
                ACTIVE: if (w_expire) r_state <= IDLE;
            endcase
            // A sticky flag being set in the same cycle as its W1C stays set.
            r_done <= w_done_set | (r_done & ~(w_wr_status & bus.writedata[STAT_DONE]));
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_status & bus.writedata[STAT_OVERRUN]));
`ifdef STROBE_PIO_IRQ_EN
            if (w_wr_status) r_irq_en <= bus.writedata[STAT_IRQ_EN];
            r_irq <= r_irq_en & (r_done | r_ovr);
`else
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
`endif
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:  bus.readdata = 32'(r_data);
            ADDR_PULSE: bus.readdata = 32'(r_mask);
            ADDR_PLEN:  bus.readdata = 32'(r_plen);
            ADDR_STATUS: begin
                bus.readdata[STAT_BUSY]    = w_busy;
                bus.readdata[STAT_DONE]    = r_done;
                bus.readdata[STAT_OVERRUN] = r_ovr;
                bus.readdata[STAT_IRQ_EN]  = r_irq_en;
            end
            default:    bus.readdata = '0;
        endcase
    end

    assign out_port    = r_out;
    assign o_dbg_state = r_state;
`ifdef STROBE_PIO_IRQ_EN
    assign irq = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = r_irq;
`endif

endmodule
